// File: rtl/seven_seg_frame_decoder.sv
// rtl/seven_seg_frame_decoder.sv - decodes a multiplexed 7-segment scan back into frames
//
// Watches the active-low segment/anode bus of a four-digit multiplexed
// seven-segment driver and rebuilds each digit0..digit3 scan into either a
// 16-bit hex value or a parity message ("EVEN" / " Odd").
//
// Ports:
//   clk_pi          in   clock, rising edge
//   rst_pi          in   synchronous active-high reset
//   seg_pi[6:0]     in   segments, active low, bit0 = top, bit6 = middle
//   dp_pi           in   decimal point, active low, expected high
//   an_pi[3:0]      in   anode select, active low, bit0 = digit0
//   num_po[15:0]    out  last accepted numeric frame, digit3 in [15:12]
//   msg_po          out  last accepted frame was a parity message
//   parity_po       out  message value, 1 = EVEN, 0 = Odd
//   frame_valid_po  out  one-cycle pulse per accepted frame
//   change_po       out  pulse with frame_valid_po when the frame differs
//   err_po          out  one-cycle pulse on protocol/decode error
//   err_cnt_po      out  saturating count of err_po pulses
module seven_seg_frame_decoder #(
  parameter int ERR_W    = 8,
  parameter int CHECK_DP = 1
) (
  input  logic             clk_pi,
  input  logic             rst_pi,
  input  logic [6:0]       seg_pi,
  input  logic             dp_pi,
  input  logic [3:0]       an_pi,
  output logic [15:0]      num_po,
  output logic             msg_po,
  output logic             parity_po,
  output logic             frame_valid_po,
  output logic             change_po,
  output logic             err_po,
  output logic [ERR_W-1:0] err_cnt_po
);

  typedef enum logic [1:0] {WAIT, D0, D1, D2} state_t;

  // Symbol codes: 0..15 are hex digits (bit4 clear), the rest are letters.
  localparam logic [4:0] SYM_BLANK = 5'd16;
  localparam logic [4:0] SYM_U     = 5'd17;
  localparam logic [4:0] SYM_N     = 5'd18;
  localparam logic [4:0] SYM_ILL   = 5'd31;

  function automatic logic [4:0] decode(input logic [6:0] lit);
    case (lit)
      7'h3F: decode = 5'd0;
      7'h06: decode = 5'd1;
      7'h5B: decode = 5'd2;
      7'h4F: decode = 5'd3;
      7'h66: decode = 5'd4;
      7'h6D: decode = 5'd5;
      7'h7D: decode = 5'd6;
      7'h07: decode = 5'd7;
      7'h7F: decode = 5'd8;
      7'h6F: decode = 5'd9;
      7'h77: decode = 5'd10;
      7'h7C: decode = 5'd11;
      7'h39: decode = 5'd12;
      7'h5E: decode = 5'd13;
      7'h79: decode = 5'd14;
      7'h71: decode = 5'd15;
      7'h00: decode = SYM_BLANK;
      7'h3E: decode = SYM_U;
      7'h37: decode = SYM_N;
      default: decode = SYM_ILL;
    endcase
  endfunction

  state_t      state, state_next;
  logic [3:0]  prev_an;
  logic [4:0]  sym0, sym1, sym2;
  logic [4:0]  sym0_next, sym1_next, sym2_next;
  logic        have_prev;

  logic [4:0]  sym;
  logic        capture;
  logic        good;
  logic [3:0]  exp_an;
  logic        is_hex, is_even, is_odd;

  logic        accept, acc_msg, acc_par, chg, err;
  logic [15:0] acc_num;

  assign sym     = decode(~seg_pi);
  assign capture = (an_pi != prev_an);
  assign good    = (sym != SYM_ILL) && !((CHECK_DP != 0) && !dp_pi);

  // sym is digit3 when the frame completes; sym0..sym2 hold the earlier digits.
  assign is_hex  = !sym[4] && !sym2[4] && !sym1[4] && !sym0[4];
  assign is_even = (sym == 5'd14) && (sym2 == SYM_U) && (sym1 == 5'd14) && (sym0 == SYM_N);
  assign is_odd  = (sym == SYM_BLANK) && (sym2 == 5'd0) && (sym1 == 5'd13) && (sym0 == 5'd13);

  always_comb begin
    case (state)
      WAIT:    exp_an = 4'b1110;
      D0:      exp_an = 4'b1101;
      D1:      exp_an = 4'b1011;
      default: exp_an = 4'b0111;
    endcase
  end

  always_comb begin
    state_next = state;
    sym0_next  = sym0;
    sym1_next  = sym1;
    sym2_next  = sym2;
    accept     = 1'b0;
    acc_msg    = msg_po;
    acc_par    = parity_po;
    acc_num    = num_po;
    err        = 1'b0;
    if (capture) begin
      if (an_pi == 4'b1111) begin
        state_next = WAIT;
      end else if (an_pi == exp_an && good) begin
        // exp_an is always one-hot, so non-one-hot anodes fall to the error arm.
        case (state)
          WAIT: begin sym0_next = sym; state_next = D0; end
          D0:   begin sym1_next = sym; state_next = D1; end
          D1:   begin sym2_next = sym; state_next = D2; end
          default: begin
            state_next = WAIT;
            if (is_hex) begin
              accept  = 1'b1;
              acc_msg = 1'b0;
              acc_num = {sym[3:0], sym2[3:0], sym1[3:0], sym0[3:0]};
            end else if (is_even || is_odd) begin
              accept  = 1'b1;
              acc_msg = 1'b1;
              acc_par = is_even;
            end else begin
              err = 1'b1;
            end
          end
        endcase
      end else begin
        err = 1'b1;
        // A clean digit0 capture that caused the error still starts a frame.
        if (an_pi == 4'b1110 && good) begin
          sym0_next  = sym;
          state_next = D0;
        end else begin
          state_next = WAIT;
        end
      end
    end
  end

  // Parity is only meaningful for messages, so it is masked out of the key.
  assign chg = accept &&
               (!have_prev ||
                ({acc_msg, acc_msg & acc_par, acc_num} != {msg_po, msg_po & parity_po, num_po}));

  always_ff @(posedge clk_pi) begin
    if (rst_pi) begin
      state          <= WAIT;
      prev_an        <= 4'b1111;
      sym0           <= '0;
      sym1           <= '0;
      sym2           <= '0;
      num_po         <= '0;
      msg_po         <= 1'b0;
      parity_po      <= 1'b0;
      frame_valid_po <= 1'b0;
      change_po      <= 1'b0;
      err_po         <= 1'b0;
      err_cnt_po     <= '0;
      have_prev      <= 1'b0;
    end else begin
      state          <= state_next;
      prev_an        <= an_pi;
      sym0           <= sym0_next;
      sym1           <= sym1_next;
      sym2           <= sym2_next;
      frame_valid_po <= accept;
      change_po      <= chg;
      err_po         <= err;
      if (accept) begin
        num_po    <= acc_num;
        msg_po    <= acc_msg;
        parity_po <= acc_par;
        have_prev <= 1'b1;
      end
      if (err && (err_cnt_po != {ERR_W{1'b1}})) begin
        err_cnt_po <= err_cnt_po + 1'b1;
      end
    end
  end

endmodule

// File: doc/seven_seg_frame_decoder.md
Name: seven_seg_frame_decoder

Overview:
- Receive-side counterpart of the team's multiplexed four-digit seven-segment driver.
- Watches the active-low segment and anode bus the driver produces and decodes each digit pattern back to a symbol.
- Reassembles each complete digit0→digit3 scan into either a 16-bit hex value or a parity message ("EVEN" / " Odd").
- Used as an on-chip self-check and loopback monitor of the display path.

Parameters:
- ERR_W, 8, width of the saturating error counter.
- CHECK_DP, 1, if 1 then dp_pi low at a capture is an error; if 0, dp_pi is ignored.

Ports:
- clk_pi  input  1  system clock; all logic is on the rising edge.
- rst_pi  input  1  synchronous, active-high reset.
- seg_pi  input  7  segment bus, active low; bit0 = top segment, bit6 = middle segment.
- dp_pi  input  1  decimal point, active low; expected high.
- an_pi  input  4  anode select, active low; bit0 = digit0 (least significant nibble).
- num_po  output  16  last accepted numeric frame; digit3 is in [15:12].
- msg_po  output  1  1 = the last accepted frame was a parity message.
- parity_po  output  1  message value: 1 = EVEN, 0 = Odd; valid while msg_po = 1.
- frame_valid_po  output  1  one-cycle pulse per accepted frame.
- change_po  output  1  one-cycle pulse, coincident with frame_valid_po, when the frame differs from the previous accepted frame.
- err_po  output  1  one-cycle pulse on any protocol or decode error.
- err_cnt_po  output  ERR_W  saturating count of err_po pulses.

Behaviour:
- Reset: num_po = 0, msg_po = 0, parity_po = 0, all pulses = 0, err_cnt_po = 0, state = WAIT, prev_an = 4'b1111, and "no previous frame" recorded.
- No input synchroniser: inputs are in the same clock domain and are registered at the source.
- Capture event: an edge where an_pi ≠ prev_an. prev_an updates every cycle.
  - Segments are sampled only on a capture event.
  - A steady anode, even for many cycles, produces no event.
  - A segment change while the anode is unchanged is ignored.
- Symbol decode of ~seg_pi:
  - The 16 hex patterns decode to values 0–F. These are the standard driver patterns, e.g. 0 = 0111111, 1 = 0000110, 8 = 1111111, E = 1111001, d = 1011110.
  - BLANK = 0000000.
  - U = 0111110.
  - N = 0110111.
  - Any other pattern is ILLEGAL.
- State machine: WAIT, D0, D1, D2.
  - WAIT, an = 1110 event → D0, store symbol 0.
  - D0, an = 1101 → D1. D1, an = 1011 → D2.
  - D2, an = 0111 → frame complete, classify, return to WAIT.
  - After a complete frame, the next 1110 event starts a new frame (back-to-back scans are accepted continuously).
  - Event with an = 1111 → WAIT, silent abort, no error.
  - Event with a non-one-hot anode, an out-of-order one-hot anode, an ILLEGAL symbol, or a CHECK_DP violation → err_po pulse, frame aborted.
  - After an error: if the offending anode is 1110 with a legal symbol, go to D0 with it stored; otherwise go to WAIT.
- Classification on a complete frame (written digit3..digit0):
  - All four symbols hex → numeric frame: num_po = {d3, d2, d1, d0}, msg_po = 0.
  - E, U, E, N → msg_po = 1, parity_po = 1, num_po held.
  - BLANK, 0, d, d → msg_po = 1, parity_po = 0, num_po held.
  - Any other mix → err_po, nothing updated.
- Latency: outputs update at the same edge that samples digit3, so frame_valid_po is high in the cycle after the digit3 capture edge.
- change_po compares a stored 18-bit key {msg, parity-or-number} with the previous accepted frame. The first frame after reset always pulses change_po.
- err_cnt_po saturates at 2^ERR_W − 1.
- Reset mid-frame discards the partial frame; the next event must be 1110.

Test Plan:
- Reset, then driver-style scan of 0x1234 (events every 4 cycles, digit0 first) → one frame_valid_po pulse, num_po = 0x1234, change_po = 1, err_cnt_po = 0.
- Second identical 0x1234 scan → frame_valid_po = 1, change_po = 0; then scan 0xBEEF → num_po = 0xBEEF, change_po = 1.
- EVEN pattern scan → msg_po = 1, parity_po = 1, num_po stays 0xBEEF; then " Odd" scan → parity_po = 0, change_po = 1.
- Anode sequence 1110 → 1011 → err_po = 1, err_cnt_po = 1, no frame_valid_po; an immediately following full 0x00FF scan is accepted.
- Digit1 segments = ~7'b0000001 → err_po at that capture, frame aborted. Separately, dp_pi = 0 with CHECK_DP = 1 → error; with CHECK_DP = 0 → accepted.
- rst_pi asserted after digit2 → all outputs return to reset values; a following 0111 event causes no frame. Also force 300 errors with ERR_W = 8 → err_cnt_po = 255.
